// File: rtl/cpu_defs.sv
`default_nettype none
// ============================================================================
// Module      : cpu_defs
// Description : Shared definitions for the program loader: host command
//               bytes, ping reply byte and the loader state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_defs;

    localparam logic [7:0] CMD_LOAD = 8'h4C;   // 'L'
    localparam logic [7:0] CMD_RUN  = 8'h52;   // 'R'
    localparam logic [7:0] CMD_PING = 8'h50;   // 'P'
    localparam logic [7:0] ACK_PING = 8'h4B;   // 'K'

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_LADDR_HI = 4'd1,
        S_LADDR_LO = 4'd2,
        S_LEN_HI   = 4'd3,
        S_LEN_LO   = 4'd4,
        S_DATA     = 4'd5,
        S_ACK      = 4'd6,
        S_RADDR_HI = 4'd7,
        S_RADDR_LO = 4'd8,
        S_START    = 4'd9,
        S_RUNNING  = 4'd10
    } loader_state_t;

endpackage : cpu_defs
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : UART-driven bootloader. Receives load/run/ping commands,
//               writes program bytes into RAM, replies with a checksum and
//               launches the cpu at a host-supplied start address.
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader
    import cpu_defs::*;
#(
    parameter int addr_width = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  received,
    input  logic [7:0]            rx_byte,
    input  logic                  is_transmitting,
    output logic [7:0]            tx_byte,
    output logic                  transmit,
    output logic [addr_width-1:0] l_waddr,
    output logic [7:0]            dwrite,
    output logic                  write_en,
    output logic [addr_width-1:0] startaddr,
    output logic                  cpu_start,
    input  logic                  cpu_halted,
    output logic                  running
);

    localparam logic [addr_width-1:0] c_addr_one = {{(addr_width-1){1'b0}}, 1'b1};

    loader_state_t         r_state, w_state_nxt;
    logic [addr_width-1:0] r_addr, w_addr_nxt;
    logic [15:0]           r_count, w_count_nxt;
    logic [7:0]            r_cksum, w_cksum_nxt;
    logic [7:0]            r_ack, w_ack_nxt;
    logic [7:0]            r_tx_byte, w_tx_byte_nxt;
    logic                  r_transmit, w_transmit_nxt;
    logic [addr_width-1:0] r_waddr, w_waddr_nxt;
    logic [7:0]            r_dwrite, w_dwrite_nxt;
    logic                  r_we, w_we_nxt;
    logic [addr_width-1:0] r_startaddr, w_startaddr_nxt;

    // State and datapath registers; everything clears on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_count     <= '0;
            r_cksum     <= '0;
            r_ack       <= '0;
            r_tx_byte   <= '0;
            r_transmit  <= 1'b0;
            r_waddr     <= '0;
            r_dwrite    <= '0;
            r_we        <= 1'b0;
            r_startaddr <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_count     <= w_count_nxt;
            r_cksum     <= w_cksum_nxt;
            r_ack       <= w_ack_nxt;
            r_tx_byte   <= w_tx_byte_nxt;
            r_transmit  <= w_transmit_nxt;
            r_waddr     <= w_waddr_nxt;
            r_dwrite    <= w_dwrite_nxt;
            r_we        <= w_we_nxt;
            r_startaddr <= w_startaddr_nxt;
        end
    end

    // Next-state and next-datapath logic; strobes default low every cycle
    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_count_nxt     = r_count;
        w_cksum_nxt     = r_cksum;
        w_ack_nxt       = r_ack;
        w_tx_byte_nxt   = r_tx_byte;
        w_transmit_nxt  = 1'b0;
        w_waddr_nxt     = r_waddr;
        w_dwrite_nxt    = r_dwrite;
        w_we_nxt        = 1'b0;
        w_startaddr_nxt = r_startaddr;

        case (r_state)
            S_IDLE: begin
                if (received) begin
                    if (rx_byte == CMD_LOAD) begin
                        w_state_nxt = S_LADDR_HI;
                    end else if (rx_byte == CMD_RUN) begin
                        w_state_nxt = S_RADDR_HI;
                    end else if (rx_byte == CMD_PING) begin
                        w_ack_nxt   = ACK_PING;
                        w_state_nxt = S_ACK;
                    end
                end
            end
            // High address byte: bits above the address width are dropped
            S_LADDR_HI, S_RADDR_HI: begin
                if (received) begin
                    w_addr_nxt[addr_width-1:8] = rx_byte[addr_width-9:0];
                    w_state_nxt = (r_state == S_LADDR_HI) ? S_LADDR_LO : S_RADDR_LO;
                end
            end
            S_LADDR_LO: begin
                if (received) begin
                    w_addr_nxt[7:0] = rx_byte;
                    w_state_nxt     = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (received) begin
                    w_count_nxt[15:8] = rx_byte;
                    w_state_nxt       = S_LEN_LO;
                end
            end
            // A zero-length load replies immediately with a zero checksum
            S_LEN_LO: begin
                if (received) begin
                    w_count_nxt[7:0] = rx_byte;
                    w_cksum_nxt      = 8'h00;
                    if ({r_count[15:8], rx_byte} == 16'd0) begin
                        w_ack_nxt   = 8'h00;
                        w_state_nxt = S_ACK;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (received) begin
                    w_we_nxt     = 1'b1;
                    w_waddr_nxt  = r_addr;
                    w_dwrite_nxt = rx_byte;
                    w_addr_nxt   = r_addr + c_addr_one;
                    w_cksum_nxt  = r_cksum + rx_byte;
                    w_count_nxt  = r_count - 16'd1;
                    if (r_count == 16'd1) begin
                        w_ack_nxt   = r_cksum + rx_byte;
                        w_state_nxt = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (!is_transmitting) begin
                    w_tx_byte_nxt  = r_ack;
                    w_transmit_nxt = 1'b1;
                    w_state_nxt    = S_IDLE;
                end
            end
            // startaddr is latched here so it is stable before the start pulse
            S_RADDR_LO: begin
                if (received) begin
                    w_startaddr_nxt = {r_addr[addr_width-1:8], rx_byte};
                    w_addr_nxt[7:0] = rx_byte;
                    w_state_nxt     = S_START;
                end
            end
            S_START: begin
                w_state_nxt = S_RUNNING;
            end
            // The cpu owns the UART here, so received bytes are ignored
            S_RUNNING: begin
                if (cpu_halted) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign tx_byte   = r_tx_byte;
    assign transmit  = r_transmit;
    assign l_waddr   = r_waddr;
    assign dwrite    = r_dwrite;
    assign write_en  = r_we;
    assign startaddr = r_startaddr;
    assign cpu_start = (r_state == S_START);
    assign running   = (r_state == S_RUNNING);

endmodule : program_loader
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_loader
// Description : Directed self-checking bench for program_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    localparam int AW = 9;

    logic          clk;
    logic          rst;
    logic          received;
    logic [7:0]    rx_byte;
    logic          is_transmitting;
    logic [7:0]    tx_byte;
    logic          transmit;
    logic [AW-1:0] l_waddr;
    logic [7:0]    dwrite;
    logic          write_en;
    logic [AW-1:0] startaddr;
    logic          cpu_start;
    logic          cpu_halted;
    logic          running;

    int n_vec;
    int n_err;
    int cnt_we;
    int cnt_tx;
    int cnt_start;

    program_loader #(.addr_width(AW)) u_dut (
        .clk             (clk),
        .rst             (rst),
        .received        (received),
        .rx_byte         (rx_byte),
        .is_transmitting (is_transmitting),
        .tx_byte         (tx_byte),
        .transmit        (transmit),
        .l_waddr         (l_waddr),
        .dwrite          (dwrite),
        .write_en        (write_en),
        .startaddr       (startaddr),
        .cpu_start       (cpu_start),
        .cpu_halted      (cpu_halted),
        .running         (running)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled away from the active edge
    always @(negedge clk) begin
        if (write_en)  cnt_we    <= cnt_we + 1;
        if (transmit)  cnt_tx    <= cnt_tx + 1;
        if (cpu_start) cnt_start <= cnt_start + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One-cycle received pulse; returns on the negedge after capture
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_byte  = b;
        received = 1'b1;
        @(posedge clk);
        @(negedge clk);
        received = 1'b0;
    endtask

    // Data byte: the write must be visible in the cycle after the pulse
    task automatic send_data(input string tag, input logic [7:0] b, input logic [AW-1:0] a);
        send_byte(b);
        check({tag, "_we"},    {31'd0, write_en}, 32'd1);
        check({tag, "_waddr"}, {23'd0, l_waddr},  {23'd0, a});
        check({tag, "_data"},  {24'd0, dwrite},   {24'd0, b});
    endtask

    // Bounded wait for a transmit strobe, then check the byte
    task automatic wait_tx(input string tag, input logic [7:0] exp);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (transmit) seen = 1'b1;
        end
        if (seen) check(tag, {24'd0, tx_byte}, {24'd0, exp});
        else      check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    int we0, tx0, st0;

    initial begin
        n_vec = 0; n_err = 0;
        cnt_we = 0; cnt_tx = 0; cnt_start = 0;
        rst = 1'b0; received = 1'b0; rx_byte = 8'h00;
        is_transmitting = 1'b0; cpu_halted = 1'b0;
        idle_cycles(3);

        // Reset state
        check("rst_tx_byte",   {24'd0, tx_byte},   32'd0);
        check("rst_outs",      {28'd0, transmit, write_en, cpu_start, running}, 32'd0);
        check("rst_waddr",     {23'd0, l_waddr},   32'd0);
        check("rst_dwrite",    {24'd0, dwrite},    32'd0);
        check("rst_startaddr", {23'd0, startaddr}, 32'd0);
        rst = 1'b1;
        idle_cycles(2);

        // Ping
        we0 = cnt_we; tx0 = cnt_tx;
        send_byte(8'h50);
        wait_tx("ping_tx", 8'h4B);
        idle_cycles(5);
        check("ping_tx_count", cnt_tx - tx0, 32'd1);
        check("ping_no_write", cnt_we - we0, 32'd0);

        // Load three bytes at 0x010
        send_byte(8'h4C); send_byte(8'h00); send_byte(8'h10);
        send_byte(8'h00); send_byte(8'h03);
        send_data("ld0", 8'hAA, 9'h010);
        send_data("ld1", 8'hBB, 9'h011);
        send_data("ld2", 8'hCC, 9'h012);
        wait_tx("load_cksum", 8'h31);

        // Address wrap: high byte truncated to bit 8
        send_byte(8'h4C); send_byte(8'hFF); send_byte(8'hFF);
        send_byte(8'h00); send_byte(8'h02);
        send_data("wr0", 8'h11, 9'h1FF);
        send_data("wr1", 8'h22, 9'h000);
        wait_tx("wrap_cksum", 8'h33);

        // Zero-length load replies 0x00 without writing
        we0 = cnt_we;
        send_byte(8'h4C); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h00);
        wait_tx("len0_cksum", 8'h00);
        check("len0_no_write", cnt_we - we0, 32'd0);

        // ACK backpressure
        send_byte(8'h4C); send_byte(8'h00); send_byte(8'h20);
        send_byte(8'h00); send_byte(8'h01);
        is_transmitting = 1'b1;
        tx0 = cnt_tx;
        send_data("bp0", 8'h5A, 9'h020);
        idle_cycles(50);
        check("bp_held", cnt_tx - tx0, 32'd0);
        is_transmitting = 1'b0;
        wait_tx("bp_tx", 8'h5A);
        idle_cycles(5);
        check("bp_tx_once", cnt_tx - tx0, 32'd1);

        // halt outside RUNNING is ignored
        @(negedge clk); cpu_halted = 1'b1;
        @(negedge clk); cpu_halted = 1'b0;
        check("halt_idle_running", {31'd0, running}, 32'd0);

        // Run / halt
        st0 = cnt_start;
        send_byte(8'h52); send_byte(8'h01); send_byte(8'h23);
        check("run_startaddr", {23'd0, startaddr}, 32'h123);
        check("run_cpu_start", {31'd0, cpu_start}, 32'd1);
        @(negedge clk);
        check("run_running",   {31'd0, running},   32'd1);
        check("run_start_off", {31'd0, cpu_start}, 32'd0);
        we0 = cnt_we; tx0 = cnt_tx;
        send_byte(8'h4C);
        send_byte(8'h50);
        idle_cycles(5);
        check("run_ignore_rx", {31'd0, running}, 32'd1);
        check("run_no_tx",     cnt_tx - tx0, 32'd0);
        check("run_one_start", cnt_start - st0, 32'd1);
        @(negedge clk); cpu_halted = 1'b1;
        @(negedge clk); cpu_halted = 1'b0;
        check("halt_running", {31'd0, running}, 32'd0);
        send_byte(8'h50);
        wait_tx("post_halt_ping", 8'h4B);

        // Reset in the middle of a load
        send_byte(8'h4C); send_byte(8'h00); send_byte(8'h40);
        send_byte(8'h00); send_byte(8'h05);
        send_data("rl0", 8'h01, 9'h040);
        send_data("rl1", 8'h02, 9'h041);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_waddr",  {23'd0, l_waddr}, 32'd0);
        check("mid_rst_dwrite", {24'd0, dwrite},  32'd0);
        check("mid_rst_tx",     {24'd0, tx_byte}, 32'd0);
        idle_cycles(2);
        rst = 1'b1;
        tx0 = cnt_tx;
        send_byte(8'h00);
        idle_cycles(5);
        check("unknown_ignored", cnt_tx - tx0, 32'd0);
        send_byte(8'h50);
        wait_tx("post_rst_ping", 8'h4B);

        idle_cycles(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_program_loader
`default_nettype wire

// File: doc/program_loader.md
Name: program_loader

Overview:
UART-driven bootloader that sits directly upstream of the cpu. While the cpu is idle, it receives host commands over the serial receiver and writes program bytes into the shared RAM write port. It returns an 8-bit checksum to the host. On a run command it presents startaddr and pulses the cpu's start input, then stays passive until the cpu reports halted.

Parameters:
addr_width, 9, RAM address width; must match the cpu's addr_width (9..16).

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
received  input  1  one-cycle pulse: rx_byte valid
rx_byte  input  8  received UART byte
is_transmitting  input  1  UART transmitter busy
tx_byte  output  8  byte to transmit
transmit  output  1  one-cycle transmit strobe
l_waddr  output  addr_width  RAM write address
dwrite  output  8  RAM write data
write_en  output  1  RAM write enable, one cycle per byte
startaddr  output  addr_width  cpu start address
cpu_start  output  1  one-cycle pulse to the cpu start/rst input
cpu_halted  input  1  one-cycle pulse from the cpu on HLT
running  output  1  high from the cpu_start pulse until cpu_halted

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0, including tx_byte, l_waddr, dwrite and startaddr; internal addr, count and checksum cleared.
- Command bytes: 'L'=0x4C load, 'R'=0x52 run, 'P'=0x50 ping. Any other byte received in IDLE is ignored and the state stays IDLE.
- Load sequence: L, addr_hi, addr_lo, len_hi, len_lo, then len data bytes.
- Run sequence: R, addr_hi, addr_lo.
- Address formation: addr = {addr_hi[addr_width-9:0], addr_lo}; excess high bits are discarded.
- States and transitions:
  - IDLE: on L go to LADDR_HI; on R go to RADDR_HI; on P go to ACK with ack byte 0x4B.
  - LADDR_HI, LADDR_LO, LEN_HI, LEN_LO: each captures one byte on a received pulse. Without a pulse, the state holds.
  - After LEN_LO: len==0 goes to ACK with checksum 0x00; otherwise go to DATA with checksum cleared.
  - DATA: on received, in the next cycle write_en=1, l_waddr=addr, dwrite=rx_byte. Then addr<=addr+1 (wraps modulo 2^addr_width), checksum<=checksum+rx_byte (mod 256), count<=count-1. When count reaches 0, go to ACK.
  - ACK: wait while is_transmitting=1. When it is 0, tx_byte<=ack byte (checksum or 0x4B) and transmit=1 for one cycle, then go to IDLE.
  - RADDR_HI, RADDR_LO: after RADDR_LO, startaddr<=addr and go to START.
  - START: cpu_start=1 for exactly one cycle, with startaddr already stable since the previous cycle. Then go to RUNNING.
  - RUNNING: running=1. All received pulses are ignored, because the cpu owns the UART. On cpu_halted, go to IDLE and running=0 in the next cycle.
- Pulses: write_en, transmit and cpu_start each default to 0 every cycle.
- Simultaneous events:
  - received together with is_transmitting: the receive is processed; is_transmitting only matters in ACK.
  - cpu_halted outside RUNNING: ignored.
- Latency: one cycle from a received pulse to the corresponding write_en.
- Length: 16-bit, 0..65535. Lengths larger than 2^addr_width wrap over earlier writes; no error is raised.
- Mid-operation: no timeout. A truncated load stays in DATA until more bytes arrive or rst is asserted. rst during RUNNING clears running but does not reset the cpu.

Decomposition:
- Shared package cpu_defs: command byte constants CMD_LOAD, CMD_RUN, CMD_PING; the ping reply ACK_PING=0x4B; the loader state enum.
- No sub-module; a single FSM with datapath registers.

Test Plan:
- Ping: send 0x50 -> one transmit pulse with tx_byte=0x4B; no write_en.
- Load: send 4C 00 10 00 03 AA BB CC -> writes AA@0x010, BB@0x011, CC@0x012, each one cycle after its received pulse; then tx_byte=0x31 (AA+BB+CC mod 256).
- Wrap and truncation: send 4C FF FF 00 02 11 22 with addr_width=9 -> writes 0x11@0x1FF and 0x22@0x000; checksum 0x33.
- ACK backpressure: hold is_transmitting=1 for 50 cycles after the last data byte -> transmit is held off and asserted exactly once after release.
- Run/halt: send 52 01 23 -> startaddr=0x123, a single cpu_start pulse, running=1; an injected rx byte 0x4C causes no state change; a cpu_halted pulse -> running=0, and a following 0x50 is answered.
- Reset mid-load: assert rst after the second data byte -> outputs 0 immediately; after release, an unknown byte 0x00 is ignored and a ping still replies 0x4B.
